// File: rtl/c4_pkg.sv
// Shared constants, state encoding and address helper for the Connect-4 move controller.
package c4_pkg;

    localparam int ROWS       = 6;
    localparam int COLS       = 7;
    localparam int ROW_STRIDE = 4;
    localparam int MAX_MOVES  = 42;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CHECK = 2'd2,
        OVER  = 2'd3
    } c4_state_t;

    // Board write address used by the win checker: row 0 is the top row.
    function automatic logic [4:0] row_to_waddr(input logic [2:0] row);
        return 5'(int'(row) * ROW_STRIDE);
    endfunction

endpackage

// File: rtl/col_height_tracker.sv
// Per-column fill heights; reports the height and full flag of the selected column.
module col_height_tracker
    import c4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic [2:0] col,
    output logic [2:0] h,
    output logic       full
);

    logic [2:0] h_q [COLS];

    // Height counters: cleared by reset or a new game, bumped once per accepted drop.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < COLS; i++) h_q[i] <= '0;
        end else if (inc && (col < 3'(COLS)) && (h_q[col] != 3'(ROWS))) begin
            h_q[col] <= h_q[col] + 3'd1;
        end
    end

    // Select the addressed column; column 7 does not exist and reads as empty.
    always_comb begin
        h    = '0;
        full = 1'b0;
        if (col < 3'(COLS)) begin
            h    = h_q[col];
            full = (h_q[col] == 3'(ROWS));
        end
    end

endmodule

// File: rtl/c4_move_ctrl.sv
// Move controller: accepts a column, applies gravity, issues one board write,
// waits for the win checker and then ends the game or passes the turn.
//
// Handshake: a move is taken on a rising clock edge where move_valid and
// move_ready are both high; move_valid must be held until then. An illegal
// or full column in that situation yields a one-cycle reject instead.
module c4_move_ctrl
    import c4_pkg::*;
#(
    parameter int   CHECK_LAT    = 3,
    parameter logic FIRST_PLAYER = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [2:0] move_col,
    output logic       move_ready,
    output logic       wr_en,
    output logic [4:0] waddr,
    output logic [2:0] colval,
    output logic       Player,
    input  logic       winflag,
    output logic       reject,
    output logic       board_clr,
    output logic       game_over,
    output logic       winner_valid,
    output logic       draw,
    output logic [1:0] state_dbg
);

    c4_state_t  state_q, state_d;
    logic [2:0] col_q;
    logic [2:0] lat_q;
    logic [5:0] moves_q;

    logic [2:0] trk_col;
    logic [2:0] trk_h;
    logic       trk_full;

    logic accept, rej, do_inc, win, drw, turn;

    // While idle the tracker looks at the requested column, afterwards at the latched one.
    assign trk_col   = (state_q == IDLE) ? move_col : col_q;
    assign state_dbg = state_q;

    col_height_tracker u_heights (
        .clk  (clk),
        .rst  (rst),
        .clr  (new_game),
        .inc  (do_inc),
        .col  (trk_col),
        .h    (trk_h),
        .full (trk_full)
    );

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        rej        = 1'b0;
        do_inc     = 1'b0;
        win        = 1'b0;
        drw        = 1'b0;
        turn       = 1'b0;
        move_ready = (state_q == IDLE) && !game_over;
        unique case (state_q)
            IDLE: begin
                if (move_valid && move_ready) begin
                    if ((move_col < 3'(COLS)) && !trk_full) begin
                        accept  = 1'b1;
                        state_d = WRITE;
                    end else begin
                        rej = 1'b1;
                    end
                end
            end
            WRITE: begin
                do_inc  = 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                if (lat_q == 3'd0) begin
                    if (winflag) begin
                        win     = 1'b1;
                        state_d = OVER;
                    end else if (moves_q == 6'(MAX_MOVES)) begin
                        drw     = 1'b1;
                        state_d = OVER;
                    end else begin
                        turn    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; a new game behaves exactly like reset for the FSM.
    always_ff @(posedge clk) begin
        if (rst || new_game) state_q <= IDLE;
        else                 state_q <= state_d;
    end

    // Datapath and output registers; board_clr only pulses for new_game without rst.
    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            col_q        <= '0;
            lat_q        <= '0;
            moves_q      <= '0;
            wr_en        <= 1'b0;
            waddr        <= '0;
            colval       <= '0;
            Player       <= FIRST_PLAYER;
            reject       <= 1'b0;
            board_clr    <= new_game && !rst;
            game_over    <= 1'b0;
            winner_valid <= 1'b0;
            draw         <= 1'b0;
        end else begin
            board_clr <= 1'b0;
            wr_en     <= accept;
            reject    <= rej;
            if (accept) begin
                col_q  <= move_col;
                colval <= move_col;
                waddr  <= row_to_waddr(3'(ROWS - 1) - trk_h);
            end
            if (do_inc) begin
                moves_q <= moves_q + 6'd1;
                lat_q   <= 3'(CHECK_LAT - 1);
            end else if ((state_q == CHECK) && (lat_q != 3'd0)) begin
                lat_q <= lat_q - 3'd1;
            end
            if (turn) Player <= ~Player;
            if (win) begin
                game_over    <= 1'b1;
                winner_valid <= 1'b1;
            end
            if (drw) begin
                game_over <= 1'b1;
                draw      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_c4_move_ctrl.sv
// Directed bench for c4_move_ctrl with a write scoreboard and a small game model.
module tb_c4_move_ctrl;
    import c4_pkg::*;

    localparam int CHECK_LAT = 3;

    logic       clk = 1'b0;
    logic       rst, new_game, move_valid, winflag;
    logic [2:0] move_col;
    logic       move_ready, wr_en, Player, reject, board_clr;
    logic       game_over, winner_valid, draw;
    logic [4:0] waddr;
    logic [2:0] colval;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // Expected board writes: {waddr, colval, Player}
    logic [8:0] exp_q[$];

    // Game model
    int   m_h [7];
    int   m_moves;
    logic m_player, m_win, m_draw;
    int   c;

    c4_move_ctrl #(.CHECK_LAT(CHECK_LAT), .FIRST_PLAYER(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .new_game     (new_game),
        .move_valid   (move_valid),
        .move_col     (move_col),
        .move_ready   (move_ready),
        .wr_en        (wr_en),
        .waddr        (waddr),
        .colval       (colval),
        .Player       (Player),
        .winflag      (winflag),
        .reject       (reject),
        .board_clr    (board_clr),
        .game_over    (game_over),
        .winner_valid (winner_valid),
        .draw         (draw),
        .state_dbg    (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst === 1'b0 && wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write: observed waddr %0d col %0d, expected no write", waddr, colval);
            end else begin
                check("write", 32'({waddr, colval, Player}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_h[i] = 0;
        m_moves  = 0;
        m_player = 1'b1;
        m_win    = 1'b0;
        m_draw   = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_ready", 32'(move_ready), 1);
        check("rst_player", 32'(Player), 1);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_reject", 32'(reject), 0);
        check("rst_game_over", 32'(game_over), 0);
        check("rst_winner", 32'(winner_valid), 0);
        check("rst_draw", 32'(draw), 0);
        check("rst_waddr", 32'(waddr), 0);
        check("rst_colval", 32'(colval), 0);
    endtask

    // Waits for ready, pushes the expected write and gets the move accepted
    task automatic start_move(input logic [2:0] col, input logic w);
        int n;
        n = 0;
        while (move_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_move", 32'(move_ready), 1);
        exp_q.push_back({5'((5 - m_h[col]) * 4), col, m_player});
        move_valid = 1'b1;
        move_col   = col;
        winflag    = w;
        @(negedge clk);
        move_valid = 1'b0;
        m_h[col]++;
        m_moves++;
        check("wr_en_pulse", 32'(wr_en), 1);
    endtask

    task automatic do_move(input logic [2:0] col, input logic w);
        start_move(col, w);
        repeat (CHECK_LAT) @(negedge clk);
        check("busy_in_check", 32'(move_ready), 0);
        @(negedge clk);
        winflag = 1'b0;
        if (w) m_win = 1'b1;
        else if (m_moves == 42) m_draw = 1'b1;
        else m_player = ~m_player;
        check("ready_after_move", 32'(move_ready), 32'(!(m_win || m_draw)));
        check("player_after_move", 32'(Player), 32'(m_player));
        check("game_over_after_move", 32'(game_over), 32'(m_win || m_draw));
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_reset();
        check("board_clr_pulse", 32'(board_clr), 1);
        check_reset_values();
        @(negedge clk);
        check("board_clr_drop", 32'(board_clr), 0);
    endtask

    // One-shot bad request held for two cycles, then released
    task automatic bad_request(input logic [2:0] col);
        move_valid = 1'b1;
        move_col   = col;
        @(negedge clk);
        check("reject_pulse", 32'(reject), 1);
        check("reject_no_write", 32'(wr_en), 0);
        check("reject_ready", 32'(move_ready), 1);
        check("reject_player", 32'(Player), 32'(m_player));
        @(negedge clk);
        check("reject_held", 32'(reject), 1);
        move_valid = 1'b0;
        @(negedge clk);
        check("reject_drop", 32'(reject), 0);
        check("reject_state", 32'(state_dbg), 32'(IDLE));
    endtask

    initial begin
        rst        = 1'b1;
        new_game   = 1'b0;
        move_valid = 1'b0;
        move_col   = 3'd0;
        winflag    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_values();
        check("rst_board_clr", 32'(board_clr), 0);

        // Four drops in column 3: waddr 20,16,12,8, player 1,0,1,0
        for (int i = 0; i < 4; i++) do_move(3'd3, 1'b0);

        // Fill column 2, then a seventh request must be rejected
        for (int i = 0; i < 6; i++) do_move(3'd2, 1'b0);
        bad_request(3'd2);

        // Column 7 is illegal
        bad_request(3'd7);

        // Win on the seventh move of a fresh game
        pulse_new_game();
        for (int i = 0; i < 6; i++) do_move(3'(i), 1'b0);
        do_move(3'd6, 1'b1);
        check("win_winner_valid", 32'(winner_valid), 1);
        check("win_draw", 32'(draw), 0);
        check("win_player_is_mover", 32'(Player), 1);
        move_valid = 1'b1;
        move_col   = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("over_no_reject", 32'(reject), 0);
            check("over_no_write", 32'(wr_en), 0);
            check("over_state", 32'(state_dbg), 32'(OVER));
        end
        move_valid = 1'b0;

        // Draw: 42 moves in random legal order with winflag low
        pulse_new_game();
        for (int k = 0; k < 42; k++) begin
            c = $urandom_range(0, 6);
            while (m_h[c] == 6) c = (c + 1) % 7;
            do_move(3'(c), 1'b0);
        end
        check("draw_flag", 32'(draw), 1);
        check("draw_winner", 32'(winner_valid), 0);
        for (int i = 0; i < 7; i++) check("draw_height", 32'(dut.u_heights.h_q[i]), 6);

        // new_game during CHECK aborts the move and clears the board
        pulse_new_game();
        start_move(3'd4, 1'b0);
        @(negedge clk);
        check("mid_check_state", 32'(state_dbg), 32'(CHECK));
        pulse_new_game();
        do_move(3'd0, 1'b0);
        do_move(3'd4, 1'b0);

        // rst during CHECK aborts without board_clr
        start_move(3'd5, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("rst_mid_check_board_clr", 32'(board_clr), 0);
        check_reset_values();
        do_move(3'd5, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/c4_move_ctrl.md
# c4_move_ctrl

Move controller that drives the board write port consumed by the win checker. It accepts a player's column choice, applies gravity from per-column fill heights, and issues a single-cycle board write using the checker's encoding: row address in `waddr` as row×4, column in `colval`, owner in `Player`. It then waits a fixed latency, samples `winflag`, and either ends the game or hands the turn to the other player. It sits between the input/debounce logic and the win-check/board block.

## Interface
- `CHECK_LAT`, 3: cycles from the write pulse to sampling `winflag`, range 1–7.
- `FIRST_PLAYER`, 1'b1: `Player` value after reset or `new_game`.
- `clk  in  1  system clock; all logic on posedge`
- `rst  in  1  synchronous reset, active-high`
- `new_game  in  1  synchronous clear of game state; same effect as rst plus a board_clr pulse`
- `move_valid  in  1  move request; held until accepted`
- `move_col  in  3  requested column; 0–6 legal, 7 illegal`
- `move_ready  out  1  high only in IDLE with game not over`
- `wr_en  out  1  one-cycle board write strobe`
- `waddr  out  5  row×4, row 0 = top, row 5 = bottom (legal: 0,4,8,12,16,20)`
- `colval  out  3  column of the write`
- `Player  out  1  owner of the current or last-written move`
- `winflag  in  1  from win checker`
- `reject  out  1  one-cycle pulse: illegal column or column full`
- `board_clr  out  1  one-cycle pulse on new_game`
- `game_over  out  1  sticky until rst/new_game`
- `winner_valid  out  1  game_over due to a win; winner = Player`
- `draw  out  1  game_over with 42 moves and no win`

## Operation
- Per-column height counters h[0..6] are 3 bits each and reset to 0. Landing row = 5 − h[c]. A column is full when h[c] = 6.
- Move counter: 6 bits, 0–42.
- States:
  - IDLE
    - `move_valid` and `move_ready` with column ≤ 6 and not full: latch c, go to WRITE.
    - Illegal or full column: pulse `reject` next cycle, stay in IDLE, no write, no turn change.
  - WRITE
    - `wr_en` = 1; `waddr` = (5 − h[c])<<2; `colval` = c; `Player` unchanged.
    - h[c]++ and moves++ at the end of this cycle.
    - Go to CHECK with the latency counter = CHECK_LAT − 1.
  - CHECK
    - Count down. At 0, sample `winflag`:
      - `winflag` = 1: go to OVER with `winner_valid` = 1.
      - Else moves = 42: go to OVER with `draw` = 1.
      - Else toggle `Player` and return to IDLE.
  - OVER
    - `move_ready` = 0. Requests are ignored and produce no `reject`.
    - Exit only via rst or `new_game`.
- `waddr`, `colval`, and `Player` hold their values outside WRITE; the checker ignores them when `wr_en` = 0.
- `new_game` in any state: next cycle matches the reset state, and `board_clr` pulses for 1 cycle. `new_game` has priority over a same-cycle `move_valid`.
- rst in any state, including mid-CHECK: abort immediately; no `board_clr`.

## Timing
- Reset values:
  - state IDLE, `move_ready` = 1, `Player` = FIRST_PLAYER.
  - `wr_en`, `reject`, `board_clr`, `game_over`, `winner_valid`, `draw` = 0.
  - `waddr` = 0, `colval` = 0, h[] = 0, moves = 0.
- Accept at posedge N → `wr_en` high in cycle N+1 → `winflag` sampled at posedge N+1+CHECK_LAT → `move_ready` back at N+2+CHECK_LAT when the game continues.
- Throughput: one move per CHECK_LAT+2 cycles.
- `reject` is asserted in the cycle after the request edge. `move_ready` stays high, so a held invalid request re-rejects every cycle.
- `game_over` rises in the same cycle as entering OVER. `winner_valid` and `draw` are never both 1.

## Structure
- Package `c4_pkg`: ROWS = 6, COLS = 7, ROW_STRIDE = 4, MAX_MOVES = 42, typedef `c4_state_t` {IDLE, WRITE, CHECK, OVER}, function `row_to_waddr`.
- Sub-module `col_height_tracker`:
  - Inputs: clk, rst, clr, inc, col.
  - Outputs: h[c] for the selected column and `full`.
- Top: FSM, latency counter, move counter, output registers.

## Test plan
- Drop into column 3 four times (no win) → writes use `waddr` = 20, 16, 12, 8 with `colval` = 3; `Player` alternates 1, 0, 1, 0.
- Fill column 2 (6 drops), then a 7th request → `reject` 1-cycle pulse, no `wr_en`, `Player` unchanged, `move_ready` still 1.
- `move_col` = 7 → `reject`, no state change.
- Checker model raises `winflag` after the 7th move → `game_over` = 1, `winner_valid` = 1, `Player` = mover; further `move_valid` → no `wr_en`, no `reject`.
- 42 legal moves with `winflag` tied 0 → `draw` = 1 after the 42nd CHECK, all h[] = 6.
- Assert `new_game` mid-CHECK → `board_clr` pulse, outputs equal reset values next cycle, first drop in column 0 writes `waddr` = 20 with `Player` = 1.
